out_ram_mp: RTL and testbench

//  Parametrised multi-read-port output buffer collecting final results of the SA/PA arrays.
//  One write port, N_RD independent read ports, registered read data with valid flags.

---
 rtl/out_ram_mp.sv | 159 +++++++++++++++
 tb/tb_out_ram_mp.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/out_ram_mp.sv
// out_ram_mp: multi-read-port output buffer for the SA/PA result arrays.
// One write port, N_RD independent registered read ports with valid flags,
// and a zeroing sweep that runs after reset or when clr is pulsed.
// Optional feature macro: OUT_RAM_ACCUM_EN adds the acc port. With acc=1 a
// write adds wdata to the stored word, wrapping modulo 2^DATA_W.
module out_ram_mp #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 4,
    parameter  int N_RD   = 4,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     ce,
    input  logic                     clr,
    input  logic                     we,
    input  logic [AW-1:0]            waddr,
    input  logic [DATA_W-1:0]        wdata,
`ifdef OUT_RAM_ACCUM_EN
    input  logic                     acc,
`endif
    input  logic [N_RD-1:0]          rd_en,
    input  logic [N_RD*AW-1:0]       raddr,
    output logic [N_RD*DATA_W-1:0]   rdata,
    output logic [N_RD-1:0]          rvalid,
    output logic                     busy
);

    typedef enum logic {
        S_CLEAR,
        S_READY
    } state_t;

    // One extra bit so DEPTH itself is representable when DEPTH == 2**AW
    localparam logic [AW:0]   DEPTH_W  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    state_t                   r_state;
    logic [AW-1:0]            r_clr_ptr;
    logic [DATA_W-1:0]        r_mem [DEPTH];
    logic [N_RD*DATA_W-1:0]   r_rdata;
    logic [N_RD-1:0]          r_rvalid;

    logic                     w_active;
    logic                     w_waddr_ok;
    logic                     w_wr_en;
    logic [DATA_W-1:0]        w_wr_word;
    logic [DATA_W-1:0]        w_rd_word [N_RD];
    logic                     w_mem_we;
    logic [AW-1:0]            w_mem_addr;
    logic [DATA_W-1:0]        w_mem_din;

    // Normal operation only in READY with ce high and no clear request
    assign w_active   = (r_state == S_READY) && ce && !clr;
    assign w_waddr_ok = ({1'b0, waddr} < DEPTH_W);
    assign w_wr_en    = w_active && we && w_waddr_ok;

`ifdef OUT_RAM_ACCUM_EN
    logic [DATA_W-1:0] w_cur_word;

    // Current stored word for the accumulate path; out-of-range reads as zero
    always_comb begin
        w_cur_word = '0;
        if (w_waddr_ok) begin
            w_cur_word = r_mem[waddr];
        end
    end

    assign w_wr_word = acc ? (w_cur_word + wdata) : wdata;
`else
    assign w_wr_word = wdata;
`endif

    // Per-port read word: out-of-range -> 0, same-address write -> bypass, else memory
    always_comb begin
        for (int unsigned i = 0; i < N_RD; i++) begin
            w_rd_word[i] = '0;
            if ({1'b0, raddr[i*AW +: AW]} < DEPTH_W) begin
                if (we && (raddr[i*AW +: AW] == waddr)) begin
                    w_rd_word[i] = w_wr_word;
                end else begin
                    w_rd_word[i] = r_mem[raddr[i*AW +: AW]];
                end
            end
        end
    end

    // Single memory write port shared by the zeroing sweep and user writes
    always_comb begin
        w_mem_we   = 1'b0;
        w_mem_addr = waddr;
        w_mem_din  = w_wr_word;
        if (!rst) begin
            if (r_state == S_CLEAR) begin
                w_mem_we   = 1'b1;
                w_mem_addr = r_clr_ptr;
                w_mem_din  = '0;
            end else if (w_wr_en) begin
                w_mem_we   = 1'b1;
            end
        end
    end

    // Storage array, no reset: contents are zeroed by the sweep instead
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_din;
        end
    end

    // Control FSM with registered read data and valid flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_CLEAR;
            r_clr_ptr <= '0;
            r_rdata   <= '0;
            r_rvalid  <= '0;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    r_rvalid <= '0;
                    if (clr) begin
                        r_clr_ptr <= '0;
                    end else if (r_clr_ptr == LAST_PTR) begin
                        r_clr_ptr <= '0;
                        r_state   <= S_READY;
                    end else begin
                        r_clr_ptr <= r_clr_ptr + AW'(1);
                    end
                end
                S_READY: begin
                    if (clr) begin
                        r_state   <= S_CLEAR;
                        r_clr_ptr <= '0;
                        r_rvalid  <= '0;
                    end else if (ce) begin
                        r_rvalid <= rd_en;
                        for (int unsigned i = 0; i < N_RD; i++) begin
                            if (rd_en[i]) begin
                                r_rdata[i*DATA_W +: DATA_W] <= w_rd_word[i];
                            end
                        end
                    end else begin
                        r_rvalid <= '0;
                    end
                end
                default: begin
                    r_state   <= S_CLEAR;
                    r_clr_ptr <= '0;
                end
            endcase
        end
    end

    assign rdata  = r_rdata;
    assign rvalid = r_rvalid;
    assign busy   = (r_state == S_CLEAR);

endmodule

// File: tb/tb_out_ram_mp.sv
// Testbench for out_ram_mp: a DEPTH=4 instance and a DEPTH=5 instance.
// Vectors carry stimulus plus the expected outputs one cycle later; the
// expectation is queued when the vector is driven and checked after the edge.
module tb_out_ram_mp;

    typedef struct packed {
        logic        dut5;
        logic        clr;
        logic        ce;
        logic        we;
        logic        acc;
        logic [2:0]  waddr;
        logic [7:0]  wdata;
        logic [3:0]  rd_en;
        logic [11:0] raddr;      // port i at [i*3 +: 3]
        logic        exp_busy;
        logic [3:0]  exp_rvalid;
        logic [31:0] exp_rdata;
    } vec_t;

    typedef struct packed {
        logic        dut5;
        logic        busy;
        logic [3:0]  rvalid;
        logic [31:0] rdata;
    } exp_t;

    logic        clk;
    logic        rst;

    logic        ce4, clr4, we4;
    logic [1:0]  waddr4;
    logic [7:0]  wdata4;
    logic [3:0]  rd_en4;
    logic [7:0]  raddr4;
    logic [31:0] rdata4;
    logic [3:0]  rvalid4;
    logic        busy4;

    logic        ce5, clr5, we5;
    logic [2:0]  waddr5;
    logic [7:0]  wdata5;
    logic [3:0]  rd_en5;
    logic [11:0] raddr5;
    logic [31:0] rdata5;
    logic [3:0]  rvalid5;
    logic        busy5;

`ifdef OUT_RAM_ACCUM_EN
    logic        acc4, acc5;
`endif

    int total;
    int bad;

    exp_t sb[$];
    vec_t vq_main[$];
    vec_t vq_acc[$];

    out_ram_mp #(.DATA_W(8), .DEPTH(4), .N_RD(4)) u4 (
        .clk    (clk),
        .rst    (rst),
        .ce     (ce4),
        .clr    (clr4),
        .we     (we4),
        .waddr  (waddr4),
        .wdata  (wdata4),
`ifdef OUT_RAM_ACCUM_EN
        .acc    (acc4),
`endif
        .rd_en  (rd_en4),
        .raddr  (raddr4),
        .rdata  (rdata4),
        .rvalid (rvalid4),
        .busy   (busy4)
    );

    out_ram_mp #(.DATA_W(8), .DEPTH(5), .N_RD(4)) u5 (
        .clk    (clk),
        .rst    (rst),
        .ce     (ce5),
        .clr    (clr5),
        .we     (we5),
        .waddr  (waddr5),
        .wdata  (wdata5),
`ifdef OUT_RAM_ACCUM_EN
        .acc    (acc5),
`endif
        .rd_en  (rd_en5),
        .raddr  (raddr5),
        .rdata  (rdata5),
        .rvalid (rvalid5),
        .busy   (busy5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(
        input logic d5, input logic cl, input logic c, input logic w, input logic a,
        input logic [2:0] wa, input logic [7:0] wd, input logic [3:0] re,
        input logic [2:0] a3, input logic [2:0] a2, input logic [2:0] a1, input logic [2:0] a0,
        input logic eb, input logic [3:0] ev, input logic [31:0] ed);
        vec_t v;
        v.dut5 = d5; v.clr = cl; v.ce = c; v.we = w; v.acc = a;
        v.waddr = wa; v.wdata = wd; v.rd_en = re;
        v.raddr = {a3, a2, a1, a0};
        v.exp_busy = eb; v.exp_rvalid = ev; v.exp_rdata = ed;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    task automatic idle();
        ce4 = 1'b0; clr4 = 1'b0; we4 = 1'b0; waddr4 = '0; wdata4 = '0; rd_en4 = '0; raddr4 = '0;
        ce5 = 1'b0; clr5 = 1'b0; we5 = 1'b0; waddr5 = '0; wdata5 = '0; rd_en5 = '0; raddr5 = '0;
`ifdef OUT_RAM_ACCUM_EN
        acc4 = 1'b0; acc5 = 1'b0;
`endif
    endtask

    task automatic check_sb();
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard: got empty queue want one entry");
        end else begin
            e = sb.pop_front();
            if (e.dut5) begin
                chk("d5_busy",   {31'd0, busy5},   {31'd0, e.busy});
                chk("d5_rvalid", {28'd0, rvalid5}, {28'd0, e.rvalid});
                chk("d5_rdata",  rdata5,           e.rdata);
            end else begin
                chk("d4_busy",   {31'd0, busy4},   {31'd0, e.busy});
                chk("d4_rvalid", {28'd0, rvalid4}, {28'd0, e.rvalid});
                chk("d4_rdata",  rdata4,           e.rdata);
            end
        end
    endtask

    task automatic apply(input vec_t v);
        exp_t e;
        idle();
        if (v.dut5) begin
            ce5 = v.ce; clr5 = v.clr; we5 = v.we;
            waddr5 = v.waddr; wdata5 = v.wdata;
            rd_en5 = v.rd_en; raddr5 = v.raddr;
`ifdef OUT_RAM_ACCUM_EN
            acc5 = v.acc;
`endif
        end else begin
            ce4 = v.ce; clr4 = v.clr; we4 = v.we;
            waddr4 = v.waddr[1:0]; wdata4 = v.wdata;
            rd_en4 = v.rd_en;
            raddr4 = {v.raddr[10:9], v.raddr[7:6], v.raddr[4:3], v.raddr[1:0]};
`ifdef OUT_RAM_ACCUM_EN
            acc4 = v.acc;
`endif
        end
        e.dut5 = v.dut5; e.busy = v.exp_busy; e.rvalid = v.exp_rvalid; e.rdata = v.exp_rdata;
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_sb();
    endtask

    initial begin
        int n4, n5, n;

        total = 0;
        bad   = 0;

        // DEPTH=4: reads, write-first bypass, ce=0 hold
        vq_main.push_back(mk(0, 0,1,0,0, 0,8'h00, 4'hF,   3,2,1,0, 0,4'hF,   32'h00000000));
        vq_main.push_back(mk(0, 0,1,1,0, 2,8'hA5, 4'h0,   0,0,0,0, 0,4'h0,   32'h00000000));
        vq_main.push_back(mk(0, 0,1,0,0, 0,8'h00, 4'hF,   2,2,2,2, 0,4'hF,   32'hA5A5A5A5));
        vq_main.push_back(mk(0, 0,1,1,0, 1,8'h3C, 4'b0011,0,0,2,1, 0,4'b0011,32'hA5A5A53C));
        vq_main.push_back(mk(0, 0,1,1,0, 3,8'h77, 4'hF,   3,2,1,0, 0,4'hF,   32'h77A53C00));
        vq_main.push_back(mk(0, 0,0,1,0, 0,8'h55, 4'hF,   0,0,0,0, 0,4'h0,   32'h77A53C00));
        vq_main.push_back(mk(0, 0,1,0,0, 0,8'h00, 4'b0100,0,0,0,0, 0,4'b0100,32'h77003C00));
        vq_main.push_back(mk(0, 0,1,0,0, 0,8'h00, 4'h0,   1,1,1,1, 0,4'h0,   32'h77003C00));
        // clr sweep: writes and reads ignored, busy for 4 cycles, memory zeroed
        vq_main.push_back(mk(0, 1,1,1,0, 0,8'h99, 4'hF,   0,0,0,0, 1,4'h0,   32'h77003C00));
        vq_main.push_back(mk(0, 0,1,1,0, 0,8'hEE, 4'hF,   0,0,0,0, 1,4'h0,   32'h77003C00));
        vq_main.push_back(mk(0, 0,0,1,0, 1,8'hEE, 4'hF,   0,0,0,0, 1,4'h0,   32'h77003C00));
        vq_main.push_back(mk(0, 0,1,1,0, 2,8'hEE, 4'hF,   0,0,0,0, 1,4'h0,   32'h77003C00));
        vq_main.push_back(mk(0, 0,1,1,0, 3,8'hEE, 4'hF,   0,0,0,0, 0,4'h0,   32'h77003C00));
        vq_main.push_back(mk(0, 0,1,0,0, 0,8'h00, 4'hF,   3,2,1,0, 0,4'hF,   32'h00000000));
        // DEPTH=5: out-of-range write dropped, out-of-range reads return 0
        vq_main.push_back(mk(1, 0,1,1,0, 7,8'hDE, 4'hF,   7,2,1,0, 0,4'hF,   32'h00000000));
        vq_main.push_back(mk(1, 0,1,0,0, 0,8'h00, 4'hF,   7,6,5,4, 0,4'hF,   32'h00000000));
        vq_main.push_back(mk(1, 0,1,1,0, 4,8'h44, 4'hF,   6,5,4,4, 0,4'hF,   32'h00004444));
        vq_main.push_back(mk(1, 0,1,1,0, 6,8'h66, 4'b0001,0,0,0,6, 0,4'b0001,32'h00004400));
        vq_main.push_back(mk(1, 0,0,0,0, 0,8'h00, 4'hF,   4,4,4,4, 0,4'h0,   32'h00004400));
        vq_main.push_back(mk(1, 0,1,0,0, 0,8'h00, 4'b1000,4,0,0,0, 0,4'b1000,32'h44004400));

        // Accumulate: 0x10 + 0xF5 wraps to 0x05, then +0x01 -> 0x06
        vq_acc.push_back(mk(0, 0,1,1,0, 3,8'h10, 4'h0,    0,0,0,0, 0,4'h0,   32'h00000000));
        vq_acc.push_back(mk(0, 0,1,1,1, 3,8'hF5, 4'b0001, 0,0,0,3, 0,4'b0001,32'h00000005));
        vq_acc.push_back(mk(0, 0,1,1,1, 3,8'h01, 4'b0010, 0,0,3,0, 0,4'b0010,32'h00000605));
        vq_acc.push_back(mk(0, 0,1,0,0, 0,8'h00, 4'b0100, 0,3,0,0, 0,4'b0100,32'h00060605));

        // Reset: state right after the reset edge, then sweep length per instance
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_busy",   {31'd0, busy4},   32'd1);
        chk("rst_rvalid", {28'd0, rvalid4}, 32'd0);
        chk("rst_rdata",  rdata4,           32'd0);
        rst = 1'b0;
        n4 = 0;
        n5 = 0;
        for (int k = 0; k < 20; k++) begin
            if (busy4) n4++;
            if (busy5) n5++;
            if (!busy4 && !busy5) break;
            @(posedge clk);
            #1;
        end
        chk("rst_sweep_len_d4", n4, 32'd4);
        chk("rst_sweep_len_d5", n5, 32'd5);

        for (int i = 0; i < vq_main.size(); i++) begin
            apply(vq_main[i]);
        end

        // A second clr mid-sweep restarts it: busy lasts 4 cycles after it
        idle();
        clr4 = 1'b1; ce4 = 1'b1; rd_en4 = 4'hF;
        @(posedge clk);
        #1;
        chk("clr2_busy0", {31'd0, busy4}, 32'd1);
        clr4 = 1'b0;
        @(posedge clk);
        #1;
        chk("clr2_busy1", {31'd0, busy4}, 32'd1);
        clr4 = 1'b1;
        @(posedge clk);
        #1;
        clr4 = 1'b0;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            if (!busy4) break;
            n++;
            chk("clr2_rvalid", {28'd0, rvalid4}, 32'd0);
            @(posedge clk);
            #1;
        end
        chk("clr2_sweep_len", n, 32'd4);
        chk("clr2_rdata_held", rdata4, 32'd0);
        idle();

`ifdef OUT_RAM_ACCUM_EN
        for (int i = 0; i < vq_acc.size(); i++) begin
            apply(vq_acc[i]);
        end
`endif

        idle();
        chk("sb_drained", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
